sprite_anim_renderer: RTL and testbench



---
 rtl/sprite_anim_renderer.sv | 143 ++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// rtl/sprite_anim_renderer.sv - multi-frame scaled sprite renderer between VGA timing and colour mapper
// Optional horizontal flip: define SPRITE_MIRROR_EN to add the mirror input.
module sprite_anim_renderer #(
  parameter int SPR_W       = 128,
  parameter int SPR_H       = 33,
  parameter int NUM_FRAMES  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_W      = 15,
  parameter int IDX_W       = 4,
  parameter int TRANSP_IDX  = 0
) (
  input  logic                          vga_clk,
  input  logic                          Reset,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank,
  input  logic [9:0]                    sprite_x,
  input  logic [9:0]                    sprite_y,
  input  logic                          start,
  input  logic                          loop,
`ifdef SPRITE_MIRROR_EN
  input  logic                          mirror,
`endif
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [IDX_W-1:0]              rom_q,
  output logic [IDX_W-1:0]              pal_index,
  input  logic [3:0]                    pal_red,
  input  logic [3:0]                    pal_green,
  input  logic [3:0]                    pal_blue,
  output logic [3:0]                    red,
  output logic [3:0]                    green,
  output logic [3:0]                    blue,
  output logic                          sprite_hit,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_FRAMES)-1:0] cur_frame
);

  localparam int FW = $clog2(NUM_FRAMES);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int CW = $clog2(SPR_W);
  localparam logic [10:0]       BOX_W    = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0]       BOX_H    = 11'(SPR_H << SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              v1_q, v1_d, v2_q;
  logic              hit_q, hit_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic              frame_tick, in_box;
  logic [10:0]       dx, dy, sx, row;
  logic [ADDR_W-1:0] col, base;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    tick_d     = tick_q;
    frame_tick = (DrawX == 10'd0) && (DrawY == 10'd480);
    // start wins over a coincident tick
    if (start) begin
      state_d = S_PLAY;
      frame_d = '0;
      tick_d  = '0;
    end else if (frame_tick && state_q == S_PLAY) begin
      if (tick_q == TW'(FRAME_TICKS - 1)) begin
        tick_d = '0;
        if (frame_q == FW'(NUM_FRAMES - 1)) begin
          if (loop) frame_d = '0;
          else      state_d = S_HOLD;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, sprite_x};
    dy     = {1'b0, DrawY} - {1'b0, sprite_y};
    in_box = !dx[10] && !dy[10] && (dx < BOX_W) && (dy < BOX_H);
    sx     = dx >> SCALE_SHIFT;
    row    = dy >> SCALE_SHIFT;
`ifdef SPRITE_MIRROR_EN
    col    = mirror ? ADDR_W'(SPR_W - 1) - ADDR_W'(sx) : ADDR_W'(sx);
`else
    col    = ADDR_W'(sx);
`endif
    base       = ADDR_W'(frame_q) * FRAME_SZ;
    rom_addr_d = in_box ? base + (ADDR_W'(row) << CW) + col : base;
    v1_d       = blank && in_box && (state_q != S_IDLE);
    // v2_q lines up with rom_q: both describe the pixel sampled two edges ago
    hit_d      = v2_q && (rom_q != IDX_W'(TRANSP_IDX));
    red_d      = hit_d ? pal_red   : 4'd0;
    green_d    = hit_d ? pal_green : 4'd0;
    blue_d     = hit_d ? pal_blue  : 4'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      tick_q     <= '0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      hit_q      <= 1'b0;
      red_q      <= 4'd0;
      green_q    <= 4'd0;
      blue_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_q     <= tick_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= v1_d;
      v2_q       <= v1_q;
      hit_q      <= hit_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pal_index  = rom_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign sprite_hit = hit_q;
  assign busy       = (state_q == S_PLAY);
  assign done       = (state_q == S_HOLD);
  assign cur_frame  = frame_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// tb/tb_sprite_anim_renderer.sv - directed self-checking bench for sprite_anim_renderer
module tb_sprite_anim_renderer;

  logic        vga_clk = 1'b0;
  logic        Reset, blank, start, loop;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q, pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        sprite_hit, busy, done;
  logic [1:0]  cur_frame;
  logic        force_transp;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_anim_renderer dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .start(start), .loop(loop),
`ifdef SPRITE_MIRROR_EN
    .mirror(mirror),
`endif
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit),
    .busy(busy), .done(done), .cur_frame(cur_frame)
  );

  // synchronous ROM: odd, never-transparent data unless forced
  always_ff @(posedge vga_clk) rom_q <= force_transp ? 4'd0 : {rom_addr[2:0], 1'b1};
  assign pal_red   = pal_index;
  assign pal_green = ~pal_index;
  assign pal_blue  = pal_index ^ 4'h3;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input bit b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  function automatic void model(input int px, input int py, input int frame,
                                output int addr, output bit inb);
    int dx, dy, col;
    dx  = px - int'(sprite_x);
    dy  = py - int'(sprite_y);
    inb = (dx >= 0) && (dy >= 0) && (dx < 256) && (dy < 66);
    col = dx / 2;
`ifdef SPRITE_MIRROR_EN
    if (mirror) col = 127 - col;
`endif
    addr = frame * 4224 + (inb ? (dy / 2) * 128 + col : 0);
  endfunction

  task automatic check_addr(input string name, input int exp);
    n_tests++;
    if (rom_addr !== 15'(exp)) begin
      n_fail++;
      $display("FAIL %s: rom_addr got %0d expected %0d", name, rom_addr, exp);
    end
  endtask

  task automatic raster_row(input int y, input int x0, input int x1, input int frame, input bit active);
    int a1 = 0, a2 = 0;
    bit h1 = 0, h2 = 0;
    for (int x = x0; x <= x1 + 2; x++) begin
      int ea, d;
      bit inb, eh;
      if (x <= x1) drive(x, y, x < 640);
      else         drive(700, y, 1'b0);
      step();
      model(x, y, frame, ea, inb);
      eh = active && inb && (x < 640) && !force_transp;
      if (x <= x1) begin
        n_tests++;
        if (rom_addr !== 15'(ea)) begin
          n_fail++;
          $display("FAIL raster_addr (%0d,%0d): got %0d expected %0d", x, y, rom_addr, ea);
        end
      end
      if (x >= x0 + 2) begin
        d = (a2 % 8) * 2 + 1;
        n_tests++;
        if (sprite_hit !== h2) begin
          n_fail++;
          $display("FAIL raster_hit (%0d,%0d): got %0b expected %0b", x - 2, y, sprite_hit, h2);
        end
        n_tests++;
        if ({red, green, blue} !== (h2 ? {4'(d), 4'(15 - d), 4'(d ^ 3)} : 12'h000)) begin
          n_fail++;
          $display("FAIL raster_rgb (%0d,%0d): got %h expected %h", x - 2, y, {red, green, blue},
                   h2 ? {4'(d), 4'(15 - d), 4'(d ^ 3)} : 12'h000);
        end
      end
      a2 = a1; h2 = h1;
      a1 = ea; h1 = eh;
    end
  endtask

  task automatic check_state(input string name, input bit eb, input bit ed, input int ef);
    n_tests++;
    if (busy !== eb || done !== ed || cur_frame !== 2'(ef)) begin
      n_fail++;
      $display("FAIL %s: busy/done/frame got %0b/%0b/%0d expected %0b/%0b/%0d",
               name, busy, done, cur_frame, eb, ed, ef);
    end
  endtask

  task automatic pulse_start();
    drive(700, 0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick();
    drive(0, 480, 1'b0);
    step();
    drive(5, 481, 1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(110, 60, 1'b1);
    step();
    step();
    Reset = 1'b0;
    check_state("reset_state", 1'b0, 1'b0, 0);
    n_tests++;
    if (sprite_hit !== 1'b0 || {red, green, blue} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: hit/rgb got %0b/%h expected 0/000", sprite_hit, {red, green, blue});
    end
    raster_row(0, 0, 639, 0, 1'b0);
    raster_row(50, 0, 639, 0, 1'b0);
    raster_row(479, 0, 639, 0, 1'b0);
    check_state("idle_after_raster", 1'b0, 1'b0, 0);
  endtask

  task automatic test_geometry();
    pulse_start();
    check_state("start_play", 1'b1, 1'b0, 0);
    drive(100, 50, 1'b1); step(); check_addr("addr_100_50", 0);
    drive(101, 51, 1'b1); step(); check_addr("addr_101_51", 0);
    drive(102, 52, 1'b1); step(); check_addr("addr_102_52", 129);
    drive(355, 115, 1'b1); step(); check_addr("addr_355_115", 32 * 128 + 127);
    raster_row(49, 95, 360, 0, 1'b1);
    raster_row(50, 95, 360, 0, 1'b1);
    raster_row(115, 95, 360, 0, 1'b1);
    raster_row(116, 95, 360, 0, 1'b1);
  endtask

  task automatic test_clip();
    sprite_x = 10'd600;
    raster_row(60, 0, 660, 0, 1'b1);
    sprite_x = 10'd100;
  endtask

  task automatic test_transparent();
    force_transp = 1'b1;
    raster_row(60, 95, 360, 0, 1'b1);
    force_transp = 1'b0;
  endtask

  task automatic test_oneshot();
    loop = 1'b0;
    pulse_start();
    for (int t = 1; t <= 32; t++) begin
      tick();
      check_state($sformatf("oneshot_tick%0d", t), t < 24, t >= 24, (t < 24) ? t / 6 : 3);
      if (t == 6) begin
        drive(100, 50, 1'b1); step(); check_addr("addr_frame1", 4224);
      end
    end
    drive(101, 51, 1'b1); step(); check_addr("addr_hold_frame3", 12672);
  endtask

  task automatic test_loop();
    loop = 1'b1;
    pulse_start();
    for (int t = 1; t <= 26; t++) begin
      tick();
      check_state($sformatf("loop_tick%0d", t), 1'b1, 1'b0, (t / 6) % 4);
    end
  endtask

  task automatic test_start_tick();
    loop = 1'b1;
    pulse_start();
    for (int t = 1; t <= 23; t++) tick();
    check_state("pre_start_tick", 1'b1, 1'b0, 3);
    drive(0, 480, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("start_tick_frame0", 1'b1, 1'b0, 0);
    for (int t = 1; t <= 5; t++) tick();
    check_state("start_tick_cnt_cleared", 1'b1, 1'b0, 0);
    tick();
    check_state("start_tick_advance", 1'b1, 1'b0, 1);
  endtask

  task automatic test_reset_midplay();
    loop = 1'b0;
    pulse_start();
    for (int t = 1; t <= 12; t++) tick();
    check_state("midplay_frame2", 1'b1, 1'b0, 2);
    drive(110, 60, 1'b1);
    step(); step(); step();
    n_tests++;
    if (sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL midplay_hit: got %0b expected 1", sprite_hit);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_state("midplay_reset_state", 1'b0, 1'b0, 0);
    check_addr("midplay_reset_addr", 0);
    n_tests++;
    if (sprite_hit !== 1'b0 || {red, green, blue} !== 12'h000) begin
      n_fail++;
      $display("FAIL midplay_reset_out: hit/rgb got %0b/%h expected 0/000", sprite_hit, {red, green, blue});
    end
    step(); step(); step();
    n_tests++;
    if (sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL midplay_idle_hit: got %0b expected 0", sprite_hit);
    end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror();
    pulse_start();
    mirror = 1'b1;
    drive(100, 50, 1'b1); step(); check_addr("mirror_100_50", 127);
    drive(102, 52, 1'b1); step(); check_addr("mirror_102_52", 128 + 126);
    raster_row(60, 95, 360, 0, 1'b1);
    mirror = 1'b0;
  endtask
`endif

  initial begin
    Reset = 1'b1; start = 1'b0; loop = 1'b0; force_transp = 1'b0;
    sprite_x = 10'd100; sprite_y = 10'd50;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    drive(700, 0, 1'b0);
    test_reset();
    test_geometry();
    test_clip();
    test_transparent();
    test_oneshot();
    test_loop();
    test_start_tick();
    test_reset_midplay();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
